dac_playback_ctrl: RTL and testbench
====================================

# dac_playback_ctrl

Sample playback controller for a two-channel SYZYGY DAC path, the transmit counterpart of the ADC capture chain. Host data arrives through a pipe-in endpoint into a dual-clock FIFO. This block reads that FIFO on the DAC clock and presents paired 16-bit samples to the DAC data path at a programmable rate. It supports a finite or continuous sample count, and provides underrun detection plus status for wire-outs and LEDs.

## Interface
- IDLE_CODE, 16'h0000, value driven on both DAC channels after reset and after `stop`.
- clk  in  1  DAC sample-domain clock; all logic rising-edge.
- reset_async  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse (trigger-in on clk); begins playback.
- stop  in  1  one-cycle pulse; aborts playback.
- rate_div  in  16  output period P = max(rate_div,1)+1 clk cycles; sampled on `start` only.
- num_samples  in  32  samples to play; 0 = continuous; sampled on `start` only.
- fifo_dout  in  32  {ch1[31:16], ch2[15:0]}; standard FIFO, data valid 1 cycle after rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe (combinational).
- dac_data_1  out  16  channel 1 sample, registered.
- dac_data_2  out  16  channel 2 sample, registered.
- dac_valid  out  1  one-cycle strobe per new sample.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on finite-run completion.
- underrun  out  1  sticky; cleared by `start`.
- sample_count  out  32  samples emitted since last `start`.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - `start` and not `stop` -> PRIME.
  - Latch rate_div and num_samples.
  - Clear sample_count, read count, underrun, hold_valid and rd_pending.
- Prefetch:
  - One hold register (hold, hold_valid) and one rd_pending flag.
  - fifo_rd_en = (PRIME|RUN) & ~fifo_empty & ~hold_valid & ~rd_pending & (num_samples==0 | reads_issued < num_samples).
  - rd_pending sets on a read. On the following edge fifo_dout is captured into hold, and rd_pending clears.
- PRIME:
  - On the edge that captures the first word -> RUN, with the divider counter loaded to 0.
- RUN tick:
  - The divider counter reloads to P-1 on each tick and counts down.
  - A tick occurs when the counter is 0.
- Tick with hold_valid:
  - dac_data <= hold.
  - dac_valid pulses; sample_count++; hold_valid clears.
- Tick with rd_pending and hold empty:
  - Bypass: dac_data <= fifo_dout directly; the word is not stored in hold.
- Tick with neither hold_valid nor rd_pending:
  - Underrun: dac_data holds its last value; no dac_valid; underrun <= 1; remain in RUN.
- Finite completion:
  - The tick emitting sample num_samples moves the state to IDLE.
  - done is high in the same cycle as that final dac_valid.
  - dac_data holds the final sample.
- stop:
  - Any state -> IDLE.
  - dac_data <= IDLE_CODE.
  - hold and any pending word are discarded; a pending FIFO word is dropped, not re-queued.
- Priority:
  - stop over start, and stop over tick in the same cycle.
  - start while busy is ignored.
- Widths:
  - sample_count, read count and num_samples are 32-bit unsigned.
  - In continuous mode counters wrap modulo 2^32; wrap has no effect on operation.
- Reset mid-operation:
  - Immediately returns to IDLE with all reset values below.

## Timing
- Reset values:
  - dac_data_1/2 = IDLE_CODE.
  - dac_valid = busy = done = underrun = 0.
  - sample_count = 0.
  - fifo_rd_en = 0.
- Start latency, with a non-empty FIFO and counting from edge E0, which samples `start`:
  - fifo_rd_en high after E0.
  - Word captured at E2.
  - First dac_valid/data visible after E3.
- Sample spacing:
  - Subsequent samples every P cycles, exactly, while the FIFO keeps up.
  - P=2 is sustainable via bypass.
- Underrun timing:
  - Shifts nothing: the tick grid stays fixed, and a late word appears on the next tick.
- stop response:
  - dac_data = IDLE_CODE and busy = 0 in the cycle after the stop edge.

## Test plan
- Reset recovery: reset_async pulsed mid-RUN (P=4) -> all outputs at reset values with no clock edge required; next `start` behaves as fresh.
- Finite run: FIFO preloaded with 8 words 0x00010002..0x00080009, rate_div=3, num_samples=5 -> five dac_valid strobes spaced 4 cycles, first after E3. Data 0x0001/0x0002 through 0x0005/0x0006. done coincides with the 5th. Exactly 5 FIFO reads; 3 words remain.
- Max rate: rate_div=0 and rate_div=1, 64 words, continuous mode -> both give a period of 2, no underrun, sample_count=64 after the last strobe.
- Underrun: continuous, P=8, FIFO holds 3 words, then a 4th written 20 cycles later -> underrun=1 at the 4th tick, with data holding the 3rd sample. The 4th sample appears on a later tick aligned to the 8-cycle grid; underrun stays set until the next `start`.
- Collisions: stop and start in the same cycle from IDLE -> stays IDLE. Stop coinciding with a tick in RUN -> no dac_valid, and dac_data=IDLE_CODE next cycle. Start while busy -> no effect on counts.
- Empty at start: start with an empty FIFO -> remains in PRIME with busy=1 and no strobes. The first word written leads to dac_valid 3 edges after its rd_en.

Source files
------------

// File: rtl/dac_playback_ctrl.sv
// Plays {ch1,ch2} FIFO words to the DAC every max(rate_div,1)+1 cycles; first sample 3 edges after start.
// One-word prefetch keeps the FIFO read ahead of the tick grid; a tick with no word flags underrun and never slips.
module dac_playback_ctrl #(
    parameter logic [15:0] IDLE_CODE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_async,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] rate_div,
    input  logic [31:0] num_samples,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] dac_data_1,
    output logic [15:0] dac_data_2,
    output logic        dac_valid,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic [31:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    state_t      state;
    logic [15:0] period_m1;
    logic [15:0] div_cnt;
    logic [31:0] target;
    logic [31:0] reads_issued;
    logic [31:0] hold;
    logic        hold_valid;
    logic        rd_pending;

    logic        reads_left;
    logic        tick;
    logic [31:0] emit_word;

    assign reads_left = (target == 32'd0) || (reads_issued < target);
    assign fifo_rd_en = (state != S_IDLE) && !fifo_empty && !hold_valid && !rd_pending && reads_left;
    assign tick       = (state == S_RUN) && (div_cnt == 16'd0);
    // A word still in flight from the FIFO is forwarded straight to the DAC when the tick lands on it.
    assign emit_word  = hold_valid ? hold : fifo_dout;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state        <= S_IDLE;
            period_m1    <= 16'd1;
            div_cnt      <= 16'd0;
            target       <= 32'd0;
            reads_issued <= 32'd0;
            hold         <= 32'd0;
            hold_valid   <= 1'b0;
            rd_pending   <= 1'b0;
            dac_data_1   <= IDLE_CODE;
            dac_data_2   <= IDLE_CODE;
            dac_valid    <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            sample_count <= 32'd0;
        end else begin
            dac_valid <= 1'b0;
            done      <= 1'b0;
            if (stop) begin
                state      <= S_IDLE;
                dac_data_1 <= IDLE_CODE;
                dac_data_2 <= IDLE_CODE;
                hold_valid <= 1'b0;
                rd_pending <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_PRIME;
                            period_m1    <= (rate_div == 16'd0) ? 16'd1 : rate_div;
                            target       <= num_samples;
                            sample_count <= 32'd0;
                            reads_issued <= 32'd0;
                            underrun     <= 1'b0;
                            hold_valid   <= 1'b0;
                            rd_pending   <= 1'b0;
                        end
                    end
                    S_PRIME: begin
                        if (fifo_rd_en) begin
                            rd_pending   <= 1'b1;
                            reads_issued <= reads_issued + 32'd1;
                        end
                        if (rd_pending) begin
                            hold       <= fifo_dout;
                            hold_valid <= 1'b1;
                            rd_pending <= 1'b0;
                            state      <= S_RUN;
                            div_cnt    <= 16'd0;
                        end
                    end
                    S_RUN: begin
                        if (fifo_rd_en) begin
                            rd_pending   <= 1'b1;
                            reads_issued <= reads_issued + 32'd1;
                        end
                        if (tick) begin
                            div_cnt <= period_m1;
                            if (hold_valid || rd_pending) begin
                                dac_data_1   <= emit_word[31:16];
                                dac_data_2   <= emit_word[15:0];
                                dac_valid    <= 1'b1;
                                sample_count <= sample_count + 32'd1;
                                hold_valid   <= 1'b0;
                                rd_pending   <= 1'b0;
                                if ((target != 32'd0) && (sample_count + 32'd1 == target)) begin
                                    state <= S_IDLE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                underrun <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt - 16'd1;
                            if (rd_pending) begin
                                hold       <= fifo_dout;
                                hold_valid <= 1'b1;
                                rd_pending <= 1'b0;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Randomized bench for dac_playback_ctrl against an event-level playback model with a FIFO model attached.
module tb_dac_playback_ctrl;

    localparam logic [15:0] IDLE_CODE = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_async;
    logic        start;
    logic        stop;
    logic [15:0] rate_div;
    logic [31:0] num_samples;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] dac_data_1;
    logic [15:0] dac_data_2;
    logic        dac_valid;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [31:0] sample_count;

    dac_playback_ctrl #(.IDLE_CODE(IDLE_CODE)) dut (
        .clk          (clk),
        .reset_async  (reset_async),
        .start        (start),
        .stop         (stop),
        .rate_div     (rate_div),
        .num_samples  (num_samples),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .dac_data_1   (dac_data_1),
        .dac_data_2   (dac_data_2),
        .dac_valid    (dac_valid),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // FIFO contents as seen by the DUT
    logic [31:0] fifo_q[$];

    // Playback model: one buffered word at most, ticks on a fixed grid of P edges
    bit          m_active, m_primed, m_buf_full, m_underrun;
    logic [31:0] m_buf, m_emitted, m_reads, m_N;
    int          m_P, cyc, m_next_tick;
    logic [15:0] e_dac1, e_dac2;
    bit          e_valid, e_done, e_rd;
    int          n_valid;

    task automatic model_reset();
        m_active   = 0;
        m_primed   = 0;
        m_buf_full = 0;
        m_underrun = 0;
        m_emitted  = 0;
        m_reads    = 0;
        e_dac1     = IDLE_CODE;
        e_dac2     = IDLE_CODE;
        e_valid    = 0;
        e_done     = 0;
    endtask

    task automatic check_outputs();
        chk("dac_valid",    32'(dac_valid),  32'(e_valid));
        chk("done",         32'(done),       32'(e_done));
        chk("busy",         32'(busy),       32'(m_active));
        chk("underrun",     32'(underrun),   32'(m_underrun));
        chk("sample_count", sample_count,    m_emitted);
        chk("dac_data_1",   32'(dac_data_1), 32'(e_dac1));
        chk("dac_data_2",   32'(dac_data_2), 32'(e_dac2));
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic flush_fifo();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    // Entered just after a falling edge; drives one rising edge and checks the result.
    task automatic step(input bit st, input bit sp);
        logic        rd;
        logic [31:0] w;
        start = st;
        stop  = sp;
        e_rd  = m_active && (fifo_q.size() > 0) && !m_buf_full && ((m_N == 0) || (m_reads < m_N));
        #1;
        rd = fifo_rd_en;
        chk("fifo_rd_en", 32'(rd), 32'(e_rd));
        @(negedge clk);
        cyc++;
        start = 1'b0;
        stop  = 1'b0;
        w = 32'hDEAD_BEEF;
        if (rd && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_dout = w;
        end
        fifo_empty = (fifo_q.size() == 0);
        e_valid = 0;
        e_done  = 0;
        if (sp) begin
            m_active   = 0;
            m_buf_full = 0;
            e_dac1     = IDLE_CODE;
            e_dac2     = IDLE_CODE;
        end else if (!m_active) begin
            if (st) begin
                m_active   = 1;
                m_primed   = 0;
                m_buf_full = 0;
                m_P        = ((rate_div == 16'd0) ? 1 : int'(rate_div)) + 1;
                m_N        = num_samples;
                m_reads    = 0;
                m_emitted  = 0;
                m_underrun = 0;
            end
        end else begin
            if (m_primed && cyc == m_next_tick) begin
                m_next_tick += m_P;
                if (m_buf_full) begin
                    e_dac1     = m_buf[31:16];
                    e_dac2     = m_buf[15:0];
                    e_valid    = 1;
                    m_emitted  = m_emitted + 1;
                    m_buf_full = 0;
                    if (m_N != 0 && m_emitted == m_N) begin
                        e_done   = 1;
                        m_active = 0;
                    end
                end else begin
                    m_underrun = 1;
                end
            end
            if (e_rd) begin
                m_reads    = m_reads + 1;
                m_buf_full = 1;
                m_buf      = w;
                if (!m_primed) begin
                    m_primed    = 1;
                    m_next_tick = cyc + 2;
                end
            end
        end
        if (dac_valid) n_valid++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic run_until_valid(input int target, input int budget);
        for (int i = 0; i < budget && n_valid < target; i++) step(0, 0);
    endtask

    task automatic begin_run(input logic [15:0] rd, input logic [31:0] n);
        rate_div    = rd;
        num_samples = n;
        n_valid     = 0;
        step(1, 0);
    endtask

    task automatic pulse_reset();
        #2 reset_async = 1'b1;
        #1;
        model_reset();
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_outputs();
        reset_async = 1'b0;
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    initial begin
        reset_async = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        rate_div    = 16'd0;
        num_samples = 32'd0;
        fifo_dout   = 32'd0;
        fifo_empty  = 1'b1;
        cyc         = 0;
        m_N         = 0;
        m_P         = 2;
        m_next_tick = 0;
        n_valid     = 0;
        model_reset();
        #2;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check_outputs();
        @(negedge clk);
        reset_async = 1'b0;

        // Finite run from a preloaded FIFO
        for (int i = 0; i < 8; i++) push_word({16'(i + 1), 16'(i + 2)});
        begin_run(16'd3, 32'd5);
        run(30);
        chk("fin_strobes", 32'(n_valid), 32'd5);
        chk("fin_left", 32'(fifo_q.size()), 32'd3);
        chk("fin_last_ch1", 32'(dac_data_1), 32'h0005);
        chk("fin_last_ch2", 32'(dac_data_2), 32'h0006);

        // Highest rate, continuous, for both rate_div=0 and rate_div=1
        for (int r = 0; r < 2; r++) begin
            flush_fifo();
            for (int i = 0; i < 64; i++) push_word($urandom);
            begin_run(16'(r), 32'd0);
            run_until_valid(64, 300);
            chk("max_strobes", 32'(n_valid), 32'd64);
            chk("max_underrun", 32'(underrun), 32'd0);
            chk("max_count", sample_count, 32'd64);
            run(3);
            step(0, 1);
        end

        // Underrun with a late fourth word
        flush_fifo();
        for (int i = 0; i < 3; i++) push_word($urandom);
        begin_run(16'd7, 32'd0);
        run_until_valid(3, 100);
        run(20);
        push_word(32'hA5A5_5A5A);
        run(40);
        chk("ur_strobes", 32'(n_valid), 32'd4);
        chk("ur_sticky", 32'(underrun), 32'd1);
        step(0, 1);
        chk("ur_after_stop", 32'(underrun), 32'd1);

        // Collisions
        step(1, 1);
        chk("col_idle", 32'(busy), 32'd0);
        flush_fifo();
        for (int i = 0; i < 6; i++) push_word($urandom);
        begin_run(16'd2, 32'd4);
        run(5);
        step(1, 0);
        run(30);
        chk("col_busy_start", 32'(n_valid), 32'd4);
        for (int i = 0; i < 10; i++) push_word($urandom);
        begin_run(16'd3, 32'd0);
        run_until_valid(2, 60);
        for (int i = 0; i < 10 && cyc + 1 != m_next_tick; i++) step(0, 0);
        step(0, 1);
        chk("col_stop_tick_valid", 32'(dac_valid), 32'd0);
        chk("col_stop_tick_data", 32'(dac_data_1), 32'(IDLE_CODE));

        // Start against an empty FIFO
        flush_fifo();
        begin_run(16'd1, 32'd2);
        run(10);
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_strobes", 32'(n_valid), 32'd0);
        push_word(32'h1234_5678);
        run(6);
        push_word(32'h9ABC_DEF0);
        run(10);
        chk("empty_strobes_end", 32'(n_valid), 32'd2);

        // Asynchronous reset mid-run, then a fresh start
        for (int i = 0; i < 10; i++) push_word($urandom);
        begin_run(16'd3, 32'd0);
        run_until_valid(2, 40);
        pulse_reset();
        begin_run(16'd3, 32'd3);
        run(20);
        chk("rst_fresh_strobes", 32'(n_valid), 32'd3);

        // Randomized runs with random stop/start collisions and inputs changing while busy
        for (int it = 0; it < 25; it++) begin
            int pre;
            pre = $urandom_range(0, 6);
            for (int i = 0; i < pre; i++) push_word($urandom);
            begin_run(16'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 10)));
            for (int c = 0; c < 120; c++) begin
                int sel;
                rate_div    = 16'($urandom);
                num_samples = $urandom;
                if ($urandom_range(0, 2) == 0) push_word($urandom);
                sel = $urandom_range(0, 239);
                if (sel < 4)       step(0, 1);
                else if (sel < 10) step(1, 0);
                else if (sel < 12) step(1, 1);
                else               step(0, 0);
            end
            step(0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
